bp_table_sched: RTL and testbench

//  Owns the branch-predictor pattern table: 2^IDX_W 2-bit saturating counters, gshare indexed.

---
 rtl/bp_table_sched.sv | 104 ++++++++++
 tb/tb_bp_table_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_table_sched.sv
// Branch-predictor pattern table (gshare-indexed 2-bit saturating counters) with a
// single-port access scheduler arbitrating round-robin between predict and update ports.
module bp_table_sched #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned CNT_INI = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_gnt,
    output logic             pred_vld,
    output logic             pred_taken,
    output logic [CNT_W-1:0] pred_cnt,
    input  logic             upd_req,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_jump,
    output logic             upd_gnt,
    output logic             upd_done,
    output logic [IDX_W-1:0] ghr,
    output logic             busy
);

    localparam int unsigned      DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INI);

    typedef enum logic [1:0] {IDLE, PRED, UPD_RD, UPD_WR} state_t;
    typedef enum logic {PORT_PRED, PORT_UPD} port_t;

    state_t           state;
    port_t            rr_last;
    logic [CNT_W-1:0] tbl [DEPTH];
    logic [IDX_W-1:0] hidx;
    logic             jump_q;
    logic [CNT_W-1:0] tmp;

    // Grants only from IDLE; on a tie the port that did not win last time goes first.
    assign pred_gnt = (state == IDLE) && pred_req && (!upd_req || (rr_last == PORT_UPD));
    assign upd_gnt  = (state == IDLE) && upd_req && (!pred_req || (rr_last == PORT_PRED));
    assign busy     = (state != IDLE);

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic up);
        if (up) begin
            return (c == CNT_MAX) ? c : c + CNT_W'(1);
        end
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    // Scheduler FSM, table and GHR; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_last    <= PORT_UPD;
            hidx       <= '0;
            jump_q     <= 1'b0;
            tmp        <= '0;
            ghr        <= '0;
            pred_vld   <= 1'b0;
            pred_taken <= 1'b0;
            pred_cnt   <= '0;
            upd_done   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= CNT_RST;
            end
        end else begin
            pred_vld <= 1'b0;
            upd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pred_gnt) begin
                        hidx    <= pred_idx ^ ghr;
                        rr_last <= PORT_PRED;
                        state   <= PRED;
                    end else if (upd_gnt) begin
                        hidx    <= upd_idx ^ ghr;
                        jump_q  <= upd_jump;
                        rr_last <= PORT_UPD;
                        state   <= UPD_RD;
                    end
                end
                PRED: begin
                    pred_cnt   <= tbl[hidx];
                    pred_taken <= tbl[hidx][CNT_W-1];
                    pred_vld   <= 1'b1;
                    state      <= IDLE;
                end
                UPD_RD: begin
                    tmp   <= tbl[hidx];
                    state <= UPD_WR;
                end
                UPD_WR: begin
                    tbl[hidx] <= cnt_next(tmp, jump_q);
                    ghr       <= {ghr[IDX_W-2:0], jump_q};
                    upd_done  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_table_sched.sv
// Self-checking bench for bp_table_sched: vector table, grant-ordering sequences,
// mid-operation reset and a long outcome stream, all checked against a gshare scoreboard.
module tb_bp_table_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pred_req = 1'b0;
    logic [3:0] pred_idx = '0;
    logic       pred_gnt, pred_vld, pred_taken;
    logic [1:0] pred_cnt;
    logic       upd_req = 1'b0;
    logic [3:0] upd_idx = '0;
    logic       upd_jump = 1'b0;
    logic       upd_gnt, upd_done, busy;
    logic [3:0] ghr;

    always #5 clk = ~clk;

    bp_table_sched #(.IDX_W(4), .CNT_W(2), .CNT_INI(1)) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_idx(pred_idx), .pred_gnt(pred_gnt),
        .pred_vld(pred_vld), .pred_taken(pred_taken), .pred_cnt(pred_cnt),
        .upd_req(upd_req), .upd_idx(upd_idx), .upd_jump(upd_jump),
        .upd_gnt(upd_gnt), .upd_done(upd_done), .ghr(ghr), .busy(busy)
    );

    typedef struct {
        bit         is_upd;
        logic [3:0] idx;
        bit         jump;
        logic [3:0] exp;   // pred_cnt for a predict, ghr for an update
    } vec_t;

    typedef struct {
        bit         is_upd;
        logic [1:0] cnt;
        logic [3:0] ghr;
        int         gcyc;
    } sb_t;

    sb_t        sbq[$];
    sb_t        e;
    logic [1:0] m_tbl [16];
    logic [3:0] m_ghr;
    logic [3:0] h;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         inflight = 1'b0;
    bit         log_en = 1'b0;
    bit         gnt_log[$];
    int         gcyc_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its cycle budget (t=%0t)", name, $time);
    endtask

    // Scoreboard: model updated and expectation pushed at each grant, popped on each pulse.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_tbl[i] = 2'd1;
            m_ghr = '0;
            sbq.delete();
            inflight = 1'b0;
        end else begin
            if (pred_vld || upd_done) begin
                chk("pulse_exclusive", 32'(pred_vld & upd_done), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", 32'(pred_vld | upd_done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind", 32'(upd_done), 32'(e.is_upd));
                    chk("latency", 32'(cyc - e.gcyc), e.is_upd ? 32'd3 : 32'd2);
                    if (e.is_upd) begin
                        chk("sb_ghr", 32'(ghr), 32'(e.ghr));
                    end else begin
                        chk("sb_pred_cnt", 32'(pred_cnt), 32'(e.cnt));
                        chk("sb_pred_taken", 32'(pred_taken), 32'(e.cnt[1]));
                    end
                end
                inflight = 1'b0;
            end else if (inflight) begin
                chk("busy_mid_op", 32'(busy), 32'd1);
            end
            if (pred_gnt || upd_gnt) begin
                chk("gnt_exclusive", 32'(pred_gnt & upd_gnt), 32'd0);
                chk("gnt_only_idle", 32'(busy), 32'd0);
                inflight = 1'b1;
                if (log_en) begin
                    gnt_log.push_back(upd_gnt);
                    gcyc_log.push_back(cyc);
                end
            end
            if (pred_gnt) begin
                h = pred_idx ^ m_ghr;
                sbq.push_back('{is_upd: 1'b0, cnt: m_tbl[h], ghr: m_ghr, gcyc: cyc});
            end else if (upd_gnt) begin
                h = upd_idx ^ m_ghr;
                if (upd_jump) m_tbl[h] = (m_tbl[h] == 2'd3) ? 2'd3 : m_tbl[h] + 2'd1;
                else          m_tbl[h] = (m_tbl[h] == 2'd0) ? 2'd0 : m_tbl[h] - 2'd1;
                m_ghr = {m_ghr[2:0], upd_jump};
                sbq.push_back('{is_upd: 1'b1, cnt: m_tbl[h], ghr: m_ghr, gcyc: cyc});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One request, held until granted; returns pred_cnt or ghr seen with the pulse.
    task automatic do_op(input bit is_upd, input logic [3:0] idx, input bit jump,
                         output logic [3:0] val);
        bit got;
        @(posedge clk); #1;
        if (is_upd) begin
            upd_req = 1'b1; upd_idx = idx; upd_jump = jump;
        end else begin
            pred_req = 1'b1; pred_idx = idx;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = is_upd ? upd_gnt : pred_gnt;
        end
        if (!got) fail("grant_wait");
        @(posedge clk); #1;
        pred_req = 1'b0; upd_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = is_upd ? upd_done : pred_vld;
        end
        if (!got) fail("pulse_wait");
        val = is_upd ? ghr : {2'b00, pred_cnt};
    endtask

    // Hold the selected requests until n grants have been logged.
    task automatic hold_reqs(input bit p, input bit u, input int n);
        gnt_log.delete();
        gcyc_log.delete();
        @(posedge clk); #1;
        pred_req = p; upd_req = u; log_en = 1'b1;
        for (int i = 0; i < 200 && gnt_log.size() < n; i++) @(posedge clk);
        #1 pred_req = 1'b0; upd_req = 1'b0; log_en = 1'b0;
        if (gnt_log.size() != n) fail("hold_grants");
        repeat (5) @(negedge clk);
    endtask

    vec_t       vecs [24];
    logic [3:0] val;
    bit         seen;

    initial begin
        vecs = '{
            '{1'b0, 4'h5, 1'b0, 4'h1}, '{1'b1, 4'h0, 1'b1, 4'h1}, '{1'b0, 4'h1, 1'b0, 4'h2},
            '{1'b1, 4'h1, 1'b1, 4'h3}, '{1'b0, 4'h3, 1'b0, 4'h3}, '{1'b1, 4'h3, 1'b1, 4'h7},
            '{1'b0, 4'h7, 1'b0, 4'h3}, '{1'b1, 4'h7, 1'b1, 4'hF}, '{1'b0, 4'hF, 1'b0, 4'h3},
            '{1'b1, 4'hF, 1'b1, 4'hF}, '{1'b0, 4'hF, 1'b0, 4'h3}, '{1'b1, 4'hF, 1'b1, 4'hF},
            '{1'b0, 4'hF, 1'b0, 4'h3}, '{1'b1, 4'hF, 1'b0, 4'hE}, '{1'b0, 4'hE, 1'b0, 4'h2},
            '{1'b1, 4'hE, 1'b0, 4'hC}, '{1'b0, 4'hC, 1'b0, 4'h1}, '{1'b1, 4'hC, 1'b0, 4'h8},
            '{1'b0, 4'h8, 1'b0, 4'h0}, '{1'b1, 4'h8, 1'b0, 4'h0}, '{1'b0, 4'h0, 1'b0, 4'h0},
            '{1'b1, 4'h0, 1'b0, 4'h0}, '{1'b0, 4'h0, 1'b0, 4'h0}, '{1'b0, 4'h9, 1'b0, 4'h1}
        };

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_pred_vld", 32'(pred_vld), 32'd0);
        chk("rst_upd_done", 32'(upd_done), 32'd0);
        chk("rst_pred_cnt", 32'(pred_cnt), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_ghr", 32'(ghr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_no_gnt", 32'({pred_gnt, upd_gnt}), 32'd0);

        // Basic predict/update, then saturation up and down on hashed entry 0.
        for (int i = 0; i < 24; i++) begin
            do_op(vecs[i].is_upd, vecs[i].idx, vecs[i].jump, val);
            if (vecs[i].is_upd) begin
                chk($sformatf("vec%0d_ghr", i), 32'(val), 32'(vecs[i].exp));
            end else begin
                chk($sformatf("vec%0d_cnt", i), 32'(val), 32'(vecs[i].exp));
                chk($sformatf("vec%0d_taken", i), 32'(pred_taken), 32'(vecs[i].exp[1]));
            end
        end
        @(negedge clk);
        chk("pred_cnt_holds", 32'(pred_cnt), 32'd1);

        // Back-to-back predicts: one grant every 2 cycles.
        pred_idx = 4'h2;
        hold_reqs(1'b1, 1'b0, 3);
        if (gcyc_log.size() == 3) begin
            chk("pp_gap0", 32'(gcyc_log[1] - gcyc_log[0]), 32'd2);
            chk("pp_gap1", 32'(gcyc_log[2] - gcyc_log[1]), 32'd2);
        end

        // Both ports held after reset: P,U,P,U,P,U with 2/3-cycle spacing.
        do_reset();
        pred_idx = 4'h5; upd_idx = 4'h0; upd_jump = 1'b1;
        hold_reqs(1'b1, 1'b1, 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
            chk($sformatf("rr_order%0d", i), 32'(gnt_log[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(gcyc_log[i] - gcyc_log[i-1]),
                           (i % 2 == 1) ? 32'd2 : 32'd3);
        end
        chk("rr_ghr", 32'(ghr), 32'h7);

        // Reset asserted while the update sits in its write cycle.
        @(posedge clk); #1 upd_req = 1'b1; upd_idx = 4'h2; upd_jump = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = upd_gnt;
        end
        if (!seen) fail("rst_mid_grant");
        @(posedge clk); #1 upd_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_ghr", 32'(ghr), 32'd0);
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= upd_done; end
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) begin @(negedge clk); seen |= upd_done; end
        chk("rst_mid_no_done", 32'(seen), 32'd0);
        chk("rst_mid_ghr_after", 32'(ghr), 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_op(1'b0, 4'(i), 1'b0, val);
            chk($sformatf("reinit_entry%0d", i), 32'(val), 32'd1);
        end

        // 64-outcome T,T,N,T stream on idx 3; scoreboard checks each prediction.
        for (int i = 0; i < 64; i++) begin
            do_op(1'b0, 4'h3, 1'b0, val);
            do_op(1'b1, 4'h3, (i % 4) != 2, val);
        end
        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
